// File: rtl/eeprom_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : eeprom_cmd_seq
//  Purpose  : Converts single-byte read/write commands from a valid/ready
//             handshake into one-cycle WR/RD pulses for the serial EEPROM
//             controller, waits for ACK (with timeout), returns a response,
//             and enforces the EEPROM internal write-cycle gap.
//  Revision : 1.0  initial release
// ============================================================================
module eeprom_cmd_seq #(
  parameter int TIMEOUT = 4096,  // WAIT_ACK cycles before aborting (min 2)
  parameter int WR_GAP  = 64     // idle cycles after a good write (min 1)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [10:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  inout  wire  [7:0]  DATA,
  input  logic        ACK
);

  // One counter serves both the ACK timeout and the write gap.
  localparam int c_cnt_max = (TIMEOUT > WR_GAP) ? TIMEOUT : WR_GAP;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(WR_GAP - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RESP     = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t               state_q;
  logic [c_cnt_w-1:0]   cnt_q;
  logic [c_cnt_w-1:0]   cnt_d;
  logic                 rw_q;
  logic [7:0]           wdata_q;
  logic                 drive_q;
  logic                 wr_q;
  logic                 rd_q;
  logic [10:0]          addr_q;
  logic                 rsp_valid_q;
  logic [7:0]           rsp_rdata_q;
  logic                 rsp_err_q;

  // Saturating increment so a stuck counter can never wrap back to zero.
  always_comb begin
    cnt_d = (cnt_q == c_cnt_sat) ? cnt_q : cnt_q + 1'b1;
  end

  // Sequencer FSM with all controller-facing and response outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= 8'h00;
      drive_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 11'h000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      // Request and response strobes are single-cycle by default.
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            rw_q    <= cmd_rw;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wr_q    <= ~cmd_rw;
            rd_q    <= cmd_rw;
            drive_q <= ~cmd_rw;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // ACK takes priority over a coincident timeout.
          if (ACK) begin
            rsp_rdata_q <= rw_q ? DATA : 8'h00;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            drive_q     <= 1'b0;
            state_q     <= S_RESP;
          end else if (cnt_q == c_to_last) begin
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            drive_q     <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          // Only a completed write needs the EEPROM internal write time.
          if (!rw_q && !rsp_err_q) begin
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_q == c_gap_last) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is a pure decode of IDLE, forced low while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && !RESET;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign WR        = wr_q;
  assign RD        = rd_q;
  assign ADDR      = addr_q;

  // Write data is only ever driven from ISSUE up to the ACK/timeout edge.
  assign DATA = drive_q ? wdata_q : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eeprom_cmd_seq
//  Purpose  : Self-checking bench for eeprom_cmd_seq: directed vector table,
//             hand-written multi-cycle sequences and randomized commands
//             checked against a transaction-level timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eeprom_cmd_seq;

  localparam int TO    = 100;
  localparam int GAP   = 64;
  localparam int NEVER = 1000000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid;
  logic        cmd_rw;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        ACK;
  wire         cmd_ready;
  wire         rsp_valid;
  wire  [7:0]  rsp_rdata;
  wire         rsp_err;
  wire         WR;
  wire         RD;
  wire  [10:0] ADDR;
  wire  [7:0]  DATA;

  logic        tb_drv_en;
  logic [7:0]  tb_drv_val;
  assign DATA = tb_drv_en ? tb_drv_val : 8'hzz;

  logic        nxt_valid;
  logic        nxt_rw;
  logic [10:0] nxt_addr;
  logic [7:0]  nxt_wdata;

  logic        mon_en;
  logic        prev_wr;
  logic        prev_rd;

  int n_chk  = 0;
  int n_pass = 0;

  eeprom_cmd_seq #(.TIMEOUT(TO), .WR_GAP(GAP)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .WR       (WR),
    .RD       (RD),
    .ADDR     (ADDR),
    .DATA     (DATA),
    .ACK      (ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Strobe hygiene: WR/RD never together and never held for two cycles.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("strobe_hygiene", 32'({WR & RD, WR & prev_wr, RD & prev_rd}), 32'd0);
    end
    prev_wr <= WR;
    prev_rd <= RD;
  end

  // Transaction model: the response lands min(d,TO)+1 cycles after the
  // request cycle (k=0), and ready returns one cycle later, plus GAP for a
  // successful write. Called at a negedge while the DUT is idle.
  task automatic run_cmd(input string tag, input logic rw, input logic [10:0] a,
                         input logic [7:0] wd, input int d, input logic [7:0] rv,
                         input int spur, input logic exp_err, input logic [7:0] exp_rd);
    int rsp_at;
    int ready_at;
    rsp_at   = (exp_err ? TO : d) + 1;
    ready_at = rsp_at + 1 + ((!rw && !exp_err) ? GAP : 0);
    cmd_valid  = 1'b1;
    cmd_rw     = rw;
    cmd_addr   = a;
    cmd_wdata  = wd;
    tb_drv_en  = 1'b1;
    tb_drv_val = 8'h3C;
    #1;
    chk({tag, "/ready_at_accept"}, 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    cmd_valid = nxt_valid;
    cmd_rw    = nxt_rw;
    cmd_addr  = nxt_addr;
    cmd_wdata = nxt_wdata;
    for (int k = 0; k <= ready_at; k++) begin
      ACK = (k == d) || (k == spur);
      if (rw) begin
        tb_drv_en  = 1'b1;
        tb_drv_val = (k < rsp_at) ? rv : 8'h3C;
      end else begin
        tb_drv_en  = (k >= rsp_at);
        tb_drv_val = 8'h3C;
      end
      #1;
      chk({tag, "/WR"}, 32'(WR), 32'(k == 0 && !rw));
      chk({tag, "/RD"}, 32'(RD), 32'(k == 0 && rw));
      if (k < rsp_at) chk({tag, "/ADDR"}, 32'(ADDR), 32'(a));
      if (!rw && k < rsp_at) chk({tag, "/DATA_wr"}, 32'(DATA), 32'(wd));
      else                   chk({tag, "/DATA_free"}, 32'(DATA), 32'(tb_drv_val));
      chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(k == rsp_at));
      if (k == rsp_at) begin
        chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "/rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      end
      chk({tag, "/cmd_ready"}, 32'(cmd_ready), 32'(k >= ready_at));
      if (k < ready_at) @(negedge CLK);
    end
  endtask

  typedef struct {
    string       tag;
    logic        rw;
    logic [10:0] addr;
    logic [7:0]  wd;
    int          d;
    logic [7:0]  rv;
    int          spur;
    logic        exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table (TO=100, GAP=64); spur is an extra ACK outside WAIT_ACK.
    vecs[0] = '{"wr_2A5", 1'b0, 11'h2A5, 8'h5C, 40,    8'h00, 51,  1'b0, 8'h00};
    vecs[1] = '{"rd_7FF", 1'b1, 11'h7FF, 8'h00, 30,    8'hA3, 32,  1'b0, 8'hA3};
    vecs[2] = '{"rd_tmo", 1'b1, 11'h000, 8'h00, NEVER, 8'h5A, -1,  1'b1, 8'h00};
    vecs[3] = '{"wr_tie", 1'b0, 11'h155, 8'hAA, 100,   8'h00, 101, 1'b0, 8'h00};
    vecs[4] = '{"rd_late",1'b1, 11'h400, 8'h00, 101,   8'h77, -1,  1'b1, 8'h00};
    vecs[5] = '{"rd_fast",1'b1, 11'h123, 8'h00, 1,     8'hFF, 0,   1'b0, 8'hFF};
    vecs[6] = '{"wr_fast",1'b0, 11'h7FE, 8'h00, 1,     8'h00, 70,  1'b0, 8'h00};
    vecs[7] = '{"wr_tmo", 1'b0, 11'h0F0, 8'hC3, NEVER, 8'h00, -1,  1'b1, 8'h00};

    RESET = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ACK = 1'b0; tb_drv_en = 1'b1; tb_drv_val = 8'h5A; mon_en = 1'b0;
    nxt_valid = 1'b0; nxt_rw = 1'b0; nxt_addr = '0; nxt_wdata = '0;

    // Reset state.
    repeat (3) @(negedge CLK);
    #1;
    chk("rst/cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst/outs", 32'({rsp_valid, rsp_err, WR, RD}), 32'd0);
    chk("rst/rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst/ADDR", 32'(ADDR), 32'd0);
    chk("rst/DATA_free", 32'(DATA), 32'h5A);
    RESET = 1'b0;
    @(negedge CLK); #1;
    chk("rst/ready_after", 32'(cmd_ready), 32'd1);
    mon_en = 1'b1;
    @(negedge CLK);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].tag, vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].d,
              vecs[i].rv, vecs[i].spur, vecs[i].exp_err, vecs[i].exp_rd);
      @(negedge CLK);
    end

    // Back-to-back: read held pending across the whole write and its gap.
    ACK = 1'b0;
    nxt_valid = 1'b1; nxt_rw = 1'b1; nxt_addr = 11'h010; nxt_wdata = 8'hEE;
    run_cmd("b2b_wr", 1'b0, 11'h010, 8'h11, 5, 8'h00, -1, 1'b0, 8'h00);
    nxt_valid = 1'b0; nxt_rw = 1'b0; nxt_addr = '0; nxt_wdata = '0;
    run_cmd("b2b_rd", 1'b1, 11'h010, 8'hEE, 7, 8'h11, -1, 1'b0, 8'h11);
    @(negedge CLK);

    // Spurious ACK pulses in IDLE: nothing may happen.
    tb_drv_en = 1'b1; tb_drv_val = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      ACK = i[0];
      @(negedge CLK); #1;
      chk("idle_ack/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_ack/cmd_ready", 32'(cmd_ready), 32'd1);
    end
    ACK = 1'b0;

    // Reset during WAIT_ACK of a write.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 11'h321; cmd_wdata = 8'h9A;
    tb_drv_en = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    #1;
    chk("rstmid/issue_WR", 32'(WR), 32'd1);
    repeat (10) @(negedge CLK);
    #1;
    chk("rstmid/DATA_driven", 32'(DATA), 32'h9A);
    RESET = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 8'h96;
    @(negedge CLK); #1;
    chk("rstmid/outs", 32'({rsp_valid, rsp_err, WR, RD, cmd_ready}), 32'd0);
    chk("rstmid/ADDR", 32'(ADDR), 32'd0);
    chk("rstmid/DATA_free", 32'(DATA), 32'h96);
    RESET = 1'b0;
    @(negedge CLK); #1;
    chk("rstmid/ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk("rstmid/no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd("rstmid_rd", 1'b1, 11'h321, 8'h00, 12, 8'h4D, -1, 1'b0, 8'h4D);
    @(negedge CLK);

    // Randomized commands against the transaction model.
    for (int i = 0; i < 25; i++) begin
      logic        rw;
      logic [10:0] a;
      logic [7:0]  wd;
      logic [7:0]  rv;
      logic        err;
      int          d;
      int          spur;
      int          rsp;
      rw  = 1'($urandom_range(0, 1));
      a   = 11'($urandom_range(0, 2047));
      wd  = 8'($urandom_range(0, 255));
      rv  = 8'($urandom_range(0, 255));
      d   = ($urandom_range(0, 5) == 0) ? TO + 1 + int'($urandom_range(0, 2))
                                        : int'($urandom_range(1, TO));
      err = (d > TO);
      rsp = (err ? TO : d) + 1;
      case ($urandom_range(0, 2))
        0:       spur = -1;
        1:       spur = 0;
        default: spur = rsp + int'($urandom_range(0, GAP));
      endcase
      run_cmd("rand", rw, a, wd, d, rv, spur, err, (rw && !err) ? rv : 8'h00);
      if ($urandom_range(0, 1) == 1) begin
        ACK = 1'b0;
        @(negedge CLK);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eeprom_cmd_seq.md
Name: eeprom_cmd_seq

Overview:
Command sequencer that sits directly upstream of the serial EEPROM read/write controller. It accepts single-byte read/write commands from the system over a valid/ready handshake and converts each into the controller's WR/RD pulse with ADDR and DATA held stable. It waits for the controller's ACK, then returns read data and a completion/error response. It also enforces the EEPROM internal write-cycle gap and a no-ACK timeout.

Parameters:
TIMEOUT, 4096, cycles to wait in WAIT_ACK for ACK before aborting with error (min 2)
WR_GAP, 64, idle cycles inserted after a successful write before the next command is accepted (min 1)

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer can accept a command
cmd_rw  input  1  1 = read, 0 = write
cmd_addr  input  11  EEPROM byte address
cmd_wdata  input  8  write data; ignored for reads
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  8  read data; 0 for writes and errors
rsp_err  output  1  qualifies rsp_valid: 1 = timeout
WR  output  1  write request pulse to controller
RD  output  1  read request pulse to controller
ADDR  output  11  address to controller
DATA  inout  8  parallel data bus shared with controller
ACK  input  1  controller end-of-transfer acknowledge

Behaviour:
- Reset values: cmd_ready=0 during RESET and 1 from the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, WR=0, RD=0, ADDR=0. DATA drive disabled (8'hzz). State=IDLE. Counters=0.
- FSM states:
  - IDLE: cmd_ready=1. cmd_valid&&cmd_ready at edge n latches rw/addr/wdata and goes to ISSUE.
  - ISSUE (one cycle): WR=1 if write, RD=1 if read. ADDR=latched addr. For writes, DATA is driven with latched wdata. Next state is WAIT_ACK and the counter clears.
  - WAIT_ACK: WR=RD=0. ADDR is held. Write data stays driven; reads leave DATA at Z. The counter increments each cycle.
    - ACK=1 sampled at edge m: latch DATA into rsp_rdata if read, else 0; rsp_err=0; go to RESP.
    - Counter reaches TIMEOUT-1 with ACK=0: rsp_err=1, rsp_rdata=0, go to RESP.
    - If ACK and timeout coincide, ACK wins.
  - RESP (one cycle): rsp_valid=1.
    - Next: GAP if write with rsp_err=0, otherwise IDLE.
    - DATA drive is released on entering RESP.
  - GAP: cmd_ready=0 for exactly WR_GAP cycles, then IDLE.
- WR/RD are exactly one-cycle pulses. The controller samples them in its idle state, so they must never be held.
- ADDR and write DATA are valid from the ISSUE cycle through the ACK cycle inclusive.
- cmd_ready is a combinational decode of state==IDLE. Commands presented outside IDLE stay pending until IDLE; there is no queue.
- Latency, read: accept at edge n, RD high in cycle n+1, rsp_valid in the cycle after ACK, cmd_ready=1 in the cycle after rsp_valid.
- Latency, write: as for read, plus WR_GAP cycles of cmd_ready=0 after rsp_valid.
- ACK seen in IDLE, ISSUE, RESP or GAP is ignored and produces no response.
- DATA is never driven during reads, in IDLE, or in GAP. This guarantees no contention with the controller's read-data drive.
- After a timeout, no gap is inserted. The next command may re-issue immediately; the controller shares RESET and is expected to return to idle on its own.
- RESET mid-operation: WR/RD, DATA drive, rsp_valid and cmd_ready return to reset values on the next edge. Any in-flight command is dropped with no response.
- Counter width: $clog2 of max(TIMEOUT, WR_GAP)+1. It saturates, never wraps.

Test Plan:
1. Write: cmd_rw=0, addr=11'h2A5, wdata=8'h5C, with the controller model ACKing 40 cycles after WR.
   - Expect a single WR pulse, ADDR=2A5 and DATA=5C held until ACK.
   - Expect rsp_valid with err=0 and rdata=0, then cmd_ready low for exactly 64 cycles.
2. Read: cmd_rw=1, addr=11'h7FF, with the model driving DATA=8'hA3 and ACKing 30 cycles after RD.
   - Expect a single RD pulse, DATA undriven by the DUT, rsp_rdata=A3, err=0.
   - Expect cmd_ready=1 the cycle after rsp_valid.
3. Timeout: read to addr 0 with ACK never asserted.
   - Expect rsp_valid with err=1 and rdata=0 exactly TIMEOUT cycles after entering WAIT_ACK.
   - Expect no GAP and the next command accepted immediately.
4. Back-to-back: cmd_valid held high with write(0x010,0x11) then read(0x010).
   - Expect the second command accepted only after GAP.
   - Expect WR/RD never both high and never high for more than one cycle.
5. Spurious ACK in IDLE and during GAP: expect no rsp_valid and no state change.
6. RESET asserted during WAIT_ACK of a write: expect all outputs at reset values next cycle, DATA=Z, no response, and a fresh read completing normally afterwards.
